// File: rtl/key_event_decoder_pkg.sv
// Shared PS/2 keyboard types and constants: prefix byte values and the frame/decode FSM encodings.
package kbd_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_DATA,
        FRM_PARITY,
        FRM_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        DEC_WAIT,
        DEC_GOT_E0,
        DEC_GOT_F0,
        DEC_GOT_E0F0
    } decode_state_t;

endpackage

// File: rtl/key_event_decoder_if.sv
// Decoded key-event bundle: the decoder drives it through master, consumers read it through slave.
interface key_event_decoder_if;

    logic       code_valid;
    logic [7:0] code_out;
    logic       extended;
    logic       is_break;
    logic       parity_err;
    logic       key_pressed;
    logic       make_pulse;
    logic       break_pulse;

    modport master (
        output code_valid, code_out, extended, is_break,
               parity_err, key_pressed, make_pulse, break_pulse
    );

    modport slave (
        input  code_valid, code_out, extended, is_break,
               parity_err, key_pressed, make_pulse, break_pulse
    );

endinterface

// File: rtl/key_event_decoder_ps2_frame_rx.sv
// PS/2 frame receiver: synchronisers, ps2_clk glitch filter, 11-bit frame FSM with idle timeout.
// byte_done / parity_err are single-cycle combinational strobes in the stop-bit sample cycle.
module ps2_frame_rx
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       parity_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q,  clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q,      filt_d;
    logic [FW-1:0] filt_cnt_q,  filt_cnt_d;
    logic [TW-1:0] tmo_cnt_q,   tmo_cnt_d;
    frame_state_t  state_q,     state_d;
    logic [2:0]    bit_cnt_q,   bit_cnt_d;
    logic [7:0]    shift_q,     shift_d;
    logic          par_q,       par_d;
    logic          sample;
    logic          bit_in;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            state_q     <= FRM_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
        end
    end

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};

        // Any sample agreeing with the filtered level restarts the run count.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
            else                                   filt_cnt_d = filt_cnt_q + 1'b1;
        end
        sample = filt_q & ~filt_d;
        bit_in = data_sync_q[1];

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_done  = 1'b0;
        parity_err = 1'b0;
        tmo_cnt_d  = (sample || state_q == FRM_IDLE) ? '0 : tmo_cnt_q + 1'b1;

        if (sample) begin
            case (state_q)
                FRM_IDLE: begin
                    if (!bit_in) begin
                        state_d   = FRM_DATA;
                        bit_cnt_d = '0;
                    end
                end
                FRM_DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = FRM_PARITY;
                end
                FRM_PARITY: begin
                    par_d   = bit_in;
                    state_d = FRM_STOP;
                end
                FRM_STOP: begin
                    if (bit_in && (^{shift_q, par_q})) byte_done  = 1'b1;
                    else                               parity_err = 1'b1;
                    state_d = FRM_IDLE;
                end
            endcase
        end else if (state_q != FRM_IDLE && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Stalled mid-frame: drop the partial byte silently.
            state_d = FRM_IDLE;
            shift_d = '0;
        end
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/key_event_decoder.sv
// PS/2 key event decoder: E0/F0 prefix decoding plus held/make/break tracking of one key.
// Build macro KEY_TYPEMATIC_EN: when defined, every matching make (including repeats) pulses make_pulse.
module key_event_decoder
    import kbd_pkg::*;
#(
    parameter logic [7:0] KEY_CODE       = 8'h29,
    parameter logic       KEY_EXTENDED   = 1'b0,
    parameter int         FILTER_LEN     = 4,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    key_event_decoder_if.master    evt
);

    logic          rx_done;
    logic [7:0]    rx_byte;
    logic          rx_perr;

    decode_state_t dec_q,         dec_d;
    logic          code_valid_q,  code_valid_d;
    logic [7:0]    code_out_q,    code_out_d;
    logic          extended_q,    extended_d;
    logic          is_break_q,    is_break_d;
    logic          parity_err_q,  parity_err_d;
    logic          key_pressed_q, key_pressed_d;
    logic          make_pulse_q,  make_pulse_d;
    logic          break_pulse_q, break_pulse_d;
    logic          ev_ext;
    logic          ev_brk;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .resetN    (resetN),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_done (rx_done),
        .byte_data (rx_byte),
        .parity_err(rx_perr)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dec_q         <= DEC_WAIT;
            code_valid_q  <= 1'b0;
            code_out_q    <= '0;
            extended_q    <= 1'b0;
            is_break_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            key_pressed_q <= 1'b0;
            make_pulse_q  <= 1'b0;
            break_pulse_q <= 1'b0;
        end else begin
            dec_q         <= dec_d;
            code_valid_q  <= code_valid_d;
            code_out_q    <= code_out_d;
            extended_q    <= extended_d;
            is_break_q    <= is_break_d;
            parity_err_q  <= parity_err_d;
            key_pressed_q <= key_pressed_d;
            make_pulse_q  <= make_pulse_d;
            break_pulse_q <= break_pulse_d;
        end
    end

    always_comb begin
        dec_d         = dec_q;
        code_valid_d  = 1'b0;
        code_out_d    = code_out_q;
        extended_d    = extended_q;
        is_break_d    = is_break_q;
        parity_err_d  = rx_perr;
        key_pressed_d = key_pressed_q;
        make_pulse_d  = 1'b0;
        break_pulse_d = 1'b0;

        ev_ext = (dec_q == DEC_GOT_E0) || (dec_q == DEC_GOT_E0F0);
        ev_brk = (dec_q == DEC_GOT_F0) || (dec_q == DEC_GOT_E0F0);

        if (rx_perr) begin
            dec_d = DEC_WAIT;
        end else if (rx_done) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                // A stray E0 after a prefix is swallowed without disturbing the sequence.
                if (dec_q == DEC_WAIT) dec_d = DEC_GOT_E0;
            end else if (rx_byte == PS2_PREFIX_BREAK && dec_q == DEC_WAIT) begin
                dec_d = DEC_GOT_F0;
            end else if (rx_byte == PS2_PREFIX_BREAK && dec_q == DEC_GOT_E0) begin
                dec_d = DEC_GOT_E0F0;
            end else begin
                dec_d        = DEC_WAIT;
                code_valid_d = 1'b1;
                code_out_d   = rx_byte;
                extended_d   = ev_ext;
                is_break_d   = ev_brk;
                if (rx_byte == KEY_CODE && ev_ext == KEY_EXTENDED) begin
                    if (ev_brk) begin
                        break_pulse_d = key_pressed_q;
                        key_pressed_d = 1'b0;
                    end else begin
`ifdef KEY_TYPEMATIC_EN
                        make_pulse_d  = 1'b1;
`else
                        make_pulse_d  = ~key_pressed_q;
`endif
                        key_pressed_d = 1'b1;
                    end
                end
            end
        end
    end

    assign evt.code_valid  = code_valid_q;
    assign evt.code_out    = code_out_q;
    assign evt.extended    = extended_q;
    assign evt.is_break    = is_break_q;
    assign evt.parity_err  = parity_err_q;
    assign evt.key_pressed = key_pressed_q;
    assign evt.make_pulse  = make_pulse_q;
    assign evt.break_pulse = break_pulse_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: two instances (space key, and extended 0x75) on shared PS/2 lines.
module tb_key_event_decoder;

    localparam int HALF = 20;
    localparam int TMO  = 300;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int nvec = 0;
    int nerr = 0;

    int cv_a = 0, mk_a = 0, bk_a = 0, pe_a = 0, both_a = 0;
    int cv_b = 0, mk_b = 0;

    key_event_decoder_if evt_a ();
    key_event_decoder_if evt_b ();

    key_event_decoder #(
        .KEY_CODE(8'h29), .KEY_EXTENDED(1'b0), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)
    ) dut_a (
        .clk(clk), .resetN(resetN), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .evt(evt_a)
    );

    key_event_decoder #(
        .KEY_CODE(8'h75), .KEY_EXTENDED(1'b1), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)
    ) dut_b (
        .clk(clk), .resetN(resetN), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .evt(evt_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evt_a.code_valid)  cv_a++;
        if (evt_a.make_pulse)  mk_a++;
        if (evt_a.break_pulse) bk_a++;
        if (evt_a.parity_err)  pe_a++;
        if (evt_a.make_pulse && evt_a.break_pulse) both_a++;
        if (evt_b.code_valid)  cv_b++;
        if (evt_b.make_pulse)  mk_b++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends bits lo..hi of the 11-bit frame {stop, parity, data, start}.
    task automatic send_bits(input logic [7:0] b, input logic flip, input int lo, input int hi);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = lo; i <= hi; i++) begin
            ps2_data = fr[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 0, 10);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        wait_clks(3);
        outs = {evt_a.code_valid, evt_a.code_out, evt_a.extended, evt_a.is_break,
                evt_a.parity_err, evt_a.key_pressed, evt_a.make_pulse, evt_a.break_pulse};
        nvec++;
        if (outs !== 15'h0) begin nerr++; $display("FAIL reset_outs: got %0h expected 0", outs); end
        resetN = 1'b1;
        wait_clks(10);
        outs = {evt_a.code_valid, evt_a.code_out, evt_a.extended, evt_a.is_break,
                evt_a.parity_err, evt_a.key_pressed, evt_a.make_pulse, evt_a.break_pulse};
        nvec++;
        if (outs !== 15'h0) begin nerr++; $display("FAIL post_reset_outs: got %0h expected 0", outs); end
    endtask

    task automatic test_make();
        int cv0, mk0;
        cv0 = cv_a; mk0 = mk_a;
        send_frame(8'h29);
        nvec++; if (cv_a - cv0 !== 1) begin nerr++; $display("FAIL make_cv: got %0d expected 1", cv_a - cv0); end
        nvec++; if (evt_a.code_out !== 8'h29) begin nerr++; $display("FAIL make_code: got %0h expected 29", evt_a.code_out); end
        nvec++; if ({evt_a.extended, evt_a.is_break} !== 2'b00) begin nerr++; $display("FAIL make_flags: got %0b expected 00", {evt_a.extended, evt_a.is_break}); end
        nvec++; if (evt_a.key_pressed !== 1'b1) begin nerr++; $display("FAIL make_held: got %0b expected 1", evt_a.key_pressed); end
        nvec++; if (mk_a - mk0 !== 1) begin nerr++; $display("FAIL make_pulse: got %0d expected 1", mk_a - mk0); end
    endtask

    task automatic test_break();
        int cv0, bk0, mk0;
        cv0 = cv_a; bk0 = bk_a; mk0 = mk_a;
        send_frame(8'hF0);
        nvec++; if (cv_a - cv0 !== 0) begin nerr++; $display("FAIL prefix_cv: got %0d expected 0", cv_a - cv0); end
        send_frame(8'h29);
        nvec++; if (cv_a - cv0 !== 1) begin nerr++; $display("FAIL break_cv: got %0d expected 1", cv_a - cv0); end
        nvec++; if ({evt_a.extended, evt_a.is_break} !== 2'b01) begin nerr++; $display("FAIL break_flags: got %0b expected 01", {evt_a.extended, evt_a.is_break}); end
        nvec++; if (evt_a.key_pressed !== 1'b0) begin nerr++; $display("FAIL break_held: got %0b expected 0", evt_a.key_pressed); end
        nvec++; if ((bk_a - bk0) !== 1 || (mk_a - mk0) !== 0) begin nerr++; $display("FAIL break_pulse: got %0d/%0d expected 1/0", bk_a - bk0, mk_a - mk0); end
    endtask

    task automatic test_extended();
        int cv0, mk0;
        cv0 = cv_b; mk0 = mk_b;
        send_frame(8'h75);
        nvec++; if (cv_b - cv0 !== 1) begin nerr++; $display("FAIL plain75_cv: got %0d expected 1", cv_b - cv0); end
        nvec++; if ({evt_b.extended, mk_b - mk0} !== {1'b0, 32'd0}) begin nerr++; $display("FAIL plain75: ext %0b make %0d expected 0/0", evt_b.extended, mk_b - mk0); end
        send_frame(8'hE0);
        send_frame(8'h75);
        nvec++; if (cv_b - cv0 !== 2) begin nerr++; $display("FAIL ext75_cv: got %0d expected 2", cv_b - cv0); end
        nvec++; if ({evt_b.extended, evt_b.is_break, evt_b.code_out} !== {2'b10, 8'h75}) begin nerr++; $display("FAIL ext75_event: got %0h expected 275", {evt_b.extended, evt_b.is_break, evt_b.code_out}); end
        nvec++; if ((mk_b - mk0) !== 1 || evt_b.key_pressed !== 1'b1) begin nerr++; $display("FAIL ext75_make: got %0d/%0b expected 1/1", mk_b - mk0, evt_b.key_pressed); end
    endtask

    task automatic test_parity_err();
        int cv0, pe0;
        cv0 = cv_a; pe0 = pe_a;
        send_bits(8'h29, 1'b1, 0, 10);
        nvec++; if (pe_a - pe0 !== 1) begin nerr++; $display("FAIL perr_pulse: got %0d expected 1", pe_a - pe0); end
        nvec++; if (cv_a - cv0 !== 0) begin nerr++; $display("FAIL perr_cv: got %0d expected 0", cv_a - cv0); end
        send_frame(8'h1C);
        nvec++; if (cv_a - cv0 !== 1 || evt_a.code_out !== 8'h1C) begin nerr++; $display("FAIL after_perr: got %0d/%0h expected 1/1c", cv_a - cv0, evt_a.code_out); end
        nvec++; if (pe_a - pe0 !== 1) begin nerr++; $display("FAIL after_perr_pe: got %0d expected 1", pe_a - pe0); end
    endtask

    task automatic test_timeout();
        int cv0;
        cv0 = cv_a;
        send_bits(8'h29, 1'b0, 0, 4);
        wait_clks(TMO + 100);
        send_frame(8'h29);
        nvec++; if (cv_a - cv0 !== 1) begin nerr++; $display("FAIL timeout_cv: got %0d expected 1", cv_a - cv0); end
        nvec++; if (evt_a.code_out !== 8'h29) begin nerr++; $display("FAIL timeout_code: got %0h expected 29", evt_a.code_out); end
    endtask

    task automatic test_back_to_back();
        int cv0, mk0, exp_mk;
        send_frame(8'hF0);
        send_frame(8'h29);
        cv0 = cv_a; mk0 = mk_a;
`ifdef KEY_TYPEMATIC_EN
        exp_mk = 3;
`else
        exp_mk = 1;
`endif
        for (int i = 0; i < 3; i++) send_frame(8'h29);
        nvec++; if (cv_a - cv0 !== 3) begin nerr++; $display("FAIL repeat_cv: got %0d expected 3", cv_a - cv0); end
        nvec++; if (mk_a - mk0 !== exp_mk) begin nerr++; $display("FAIL repeat_make: got %0d expected %0d", mk_a - mk0, exp_mk); end
        nvec++; if (evt_a.key_pressed !== 1'b1) begin nerr++; $display("FAIL repeat_held: got %0b expected 1", evt_a.key_pressed); end
    endtask

    task automatic test_reset_midframe();
        int cv0;
        logic [14:0] outs;
        send_bits(8'h29, 1'b0, 0, 4);
        resetN = 1'b0;
        #2;
        outs = {evt_a.code_valid, evt_a.code_out, evt_a.extended, evt_a.is_break,
                evt_a.parity_err, evt_a.key_pressed, evt_a.make_pulse, evt_a.break_pulse};
        nvec++; if (outs !== 15'h0) begin nerr++; $display("FAIL async_reset: got %0h expected 0", outs); end
        wait_clks(3);
        resetN = 1'b1;
        cv0 = cv_a;
        send_bits(8'h29, 1'b0, 5, 10);
        nvec++; if (cv_a - cv0 !== 0) begin nerr++; $display("FAIL remnant_cv: got %0d expected 0", cv_a - cv0); end
        wait_clks(TMO + 100);
        send_frame(8'h1C);
        nvec++; if (cv_a - cv0 !== 1 || evt_a.code_out !== 8'h1C) begin nerr++; $display("FAIL resync: got %0d/%0h expected 1/1c", cv_a - cv0, evt_a.code_out); end
        nvec++; if (evt_a.key_pressed !== 1'b0) begin nerr++; $display("FAIL resync_held: got %0b expected 0", evt_a.key_pressed); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_back_to_back();
        test_reset_midframe();
        nvec++; if (both_a !== 0) begin nerr++; $display("FAIL make_break_overlap: got %0d expected 0", both_a); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- PS/2 keyboard front end for the KEYBOARD block.
- Receives raw PS/2 clock/data, assembles 11-bit frames and decodes E0/F0 prefix sequences into scan-code events.
- Tracks one configured key and drives its held level plus make/break strobes.
- key_pressed and make_pulse feed the downstream random-latch stage directly (keyPressed / rise inputs).

Parameters:
KEY_CODE, 8'h29, scan code of the tracked key (space).
KEY_EXTENDED, 1'b0, 1 = tracked key requires the E0 prefix.
FILTER_LEN, 4, consecutive identical samples needed to accept a ps2_clk level change.
TIMEOUT_CYCLES, 100000, idle clk cycles mid-frame before the frame is aborted (2 ms at 50 MHz).

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
code_valid  out  1  one-cycle strobe: complete scan-code event decoded
code_out  out  8  scan code of last event, held until next event
extended  out  1  last event carried E0 prefix
is_break  out  1  last event carried F0 prefix
parity_err  out  1  one-cycle strobe: frame rejected (parity or stop error)
key_pressed  out  1  level: tracked key currently held
make_pulse  out  1  one-cycle strobe on tracked-key press
break_pulse  out  1  one-cycle strobe on tracked-key release

Behaviour:
- Reset: clk is clk; resetN is asynchronous, active-low. All outputs, FSMs, counters and shift register clear to 0 / IDLE / WAIT. Filtered clock resets to 1.
- Input conditioning: ps2_clk and ps2_data pass through 2-FF synchronisers. The filtered clock toggles only after FILTER_LEN consecutive samples differ from its current value. A 1->0 transition of the filtered clock is a sample event; data is taken from the synchronised ps2_data in that cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a sample event with data=0 (start bit) goes to DATA; data=1 stays in IDLE.
  - DATA: shifts 8 bits LSB first, then goes to PARITY.
  - PARITY: stores the parity bit, then goes to STOP.
  - STOP: data=1 and odd parity over the 9 bits (data + parity) gives byte_done. Otherwise parity_err pulses. Either way, return to IDLE.
- Timeout: a counter resets on every sample event. In any state other than IDLE, reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE and discards partial data. No error strobe is raised.
- Decode FSM states: WAIT, GOT_E0, GOT_F0, GOT_E0F0. On byte_done:
  - E0 in WAIT goes to GOT_E0.
  - F0 in WAIT goes to GOT_F0; F0 in GOT_E0 goes to GOT_E0F0.
  - Any other byte emits an event with extended/is_break taken from the current state, then returns to WAIT.
  - E0 received in GOT_E0 / GOT_F0 / GOT_E0F0 is ignored (state held).
  - parity_err forces WAIT.
- Latency: code_valid, code_out, extended, is_break, make_pulse and break_pulse are all registered, asserting in the cycle after the stop-bit sample event. Prefix bytes never assert code_valid.
- Match condition: code_out==KEY_CODE and extended==KEY_EXTENDED.
  - Make event: make_pulse=1 only if key_pressed was 0, then key_pressed<=1.
  - Break event: break_pulse=1 only if key_pressed was 1, then key_pressed<=0.
  - make_pulse and break_pulse are never asserted together.
- Reset mid-frame: everything clears immediately. The remainder of the in-flight frame is resynchronised by the start-bit check and the timeout.

Optional Feature:
KEY_TYPEMATIC_EN
- Defined: every matching make event, including typematic repeats while held, pulses make_pulse. key_pressed behaves unchanged.
- Undefined: repeat makes while key_pressed=1 produce no make_pulse.

Decomposition:
- Package kbd_pkg holds:
  - constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0;
  - enums frame_state_t and decode_state_t.
- Sub-module ps2_frame_rx contains synchronisers, filter, frame FSM, timeout and parity check. It outputs byte_done, byte_data[7:0] and parity_err.
- key_event_decoder instantiates ps2_frame_rx and holds the decode FSM and key tracking.

Test Plan:
- Frame 0x29 (odd parity correct) -> code_valid 1 cycle, code_out=29, extended=0, is_break=0, key_pressed=1, make_pulse 1 cycle.
- Frames F0, 29 after press -> single code_valid with is_break=1, key_pressed=0, break_pulse 1 cycle; no code_valid on the F0 byte.
- KEY_CODE=8'h75, KEY_EXTENDED=1; frames 75 then E0 75 -> first event extended=0 with no make_pulse; second event extended=1 with make_pulse.
- Frame 0x29 with flipped parity bit -> parity_err 1 cycle, no code_valid; following valid 0x1C frame -> code_valid, code_out=1C.
- 5 bits of a frame then idle > TIMEOUT_CYCLES, then full 0x29 frame -> exactly one code_valid, code_out=29.
- Frames 29, 29, 29 -> three code_valid; without KEY_TYPEMATIC_EN one make_pulse, with it three. Assert resetN low mid-frame -> all outputs 0 asynchronously, next full frame decoded normally.
